// File: rtl/dec_onehot_seq_if.sv
// Bus interface for dec_onehot_seq: select/enable/control inputs and the
// registered one-hot outputs. The complementary qn output exists only when
// DEC_SEQ_QN_EN is defined.
//
// Control protocol: there is no ready/valid pair. load and step are
// single-cycle strobes sampled at every rising clk edge. They take effect
// only while en = !nen1 & !nen2 is true. load always wins over a running
// burst. step is ignored while busy is high. done is a one-cycle pulse in
// the cycle after the final burst rotate.
interface dec_onehot_seq_if #(
    parameter int SELW = 3,
    parameter int CNTW = 4
) ();
    localparam int OUTS = 2 ** SELW;

    logic [SELW-1:0] sel;
    logic            nen1;
    logic            nen2;
    logic            load;
    logic            step;
    logic [CNTW-1:0] stepCount;
    logic [OUTS-1:0] q;
    logic            busy;
    logic            done;
`ifdef DEC_SEQ_QN_EN
    logic [OUTS-1:0] qn;
`endif

    // Driver side: the block that controls the decoder.
    modport master (
        output sel, nen1, nen2, load, step, stepCount,
`ifdef DEC_SEQ_QN_EN
        input  qn,
`endif
        input  q, busy, done
    );

    // Decoder side.
    modport slave (
        input  sel, nen1, nen2, load, step, stepCount,
`ifdef DEC_SEQ_QN_EN
        output qn,
`endif
        output q, busy, done
    );
endinterface

// File: rtl/dec_onehot_seq.sv
// dec_onehot_seq: registered 1-of-2**SELW decoder with two active-low
// enables. The decoded one-hot value can be rotated left one position per
// step, or rotated once per cycle for a counted burst.
// Optional feature macro: DEC_SEQ_QN_EN adds the complementary output qn = ~q.
module dec_onehot_seq #(
    parameter int SELW = 3,
    parameter int CNTW = 4
) (
    input  logic              clk,
    input  logic              reset,
    dec_onehot_seq_if.slave   bus,
    output logic              dbg_state_o
);
    localparam int OUTS = 2 ** SELW;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OUTS-1:0] q_q, q_d;
    logic [CNTW-1:0] rem_q, rem_d;
    logic            done_q, done_d;

    logic            en;
    logic [OUTS-1:0] q_rotl;
    logic [OUTS-1:0] sel_dec;

    assign en      = ~bus.nen1 & ~bus.nen2;
    // A zero q rotates to zero, so a step can never create a set bit.
    assign q_rotl  = {q_q[OUTS-2:0], q_q[OUTS-1]};
    assign sel_dec = {{(OUTS-1){1'b0}}, 1'b1} << bus.sel;

    // State, output and burst-counter registers. Reset clears them without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    // Next state: disable, then load, then burst rotate, then single step, else hold.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (!en) begin
            // Disable aborts everything, including a burst, without a done pulse.
            state_d = ST_IDLE;
            q_d     = '0;
            rem_d   = '0;
        end else if (bus.load) begin
            // A load during a burst restarts it with the new count.
            q_d     = sel_dec;
            rem_d   = bus.stepCount;
            state_d = (bus.stepCount != '0) ? ST_BURST : ST_IDLE;
        end else if (state_q == ST_BURST) begin
            q_d   = q_rotl;
            rem_d = rem_q - 1'b1;
            if (rem_q == CNTW'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end else if (bus.step) begin
            q_d = q_rotl;
        end
    end

    // Output drive.
    assign bus.q       = q_q;
    assign bus.busy    = (state_q == ST_BURST);
    assign bus.done    = done_q;
    assign dbg_state_o = state_q;
`ifdef DEC_SEQ_QN_EN
    assign bus.qn      = ~q_q;
`endif
endmodule

// File: tb/tb_dec_onehot_seq.sv
// Testbench for dec_onehot_seq: directed cases followed by randomized
// stimulus, checked every cycle against a position-based reference model.
module tb_dec_onehot_seq;
    localparam int SELW = 3;
    localparam int CNTW = 4;
    localparam int OUTS = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic dbg_state;
    always #5 clk = ~clk;

    dec_onehot_seq_if #(.SELW(SELW), .CNTW(CNTW)) bus ();

    dec_onehot_seq #(.SELW(SELW), .CNTW(CNTW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    // The model tracks the index of the set bit, with -1 meaning q is zero.
    int m_pos;
    int m_rem;
    bit m_busy;
    bit m_done;
    logic [OUTS-1:0] exp_q[$];

    function automatic logic [OUTS-1:0] pos_to_q(int p);
        logic [OUTS-1:0] v;
        v = '0;
        if (p >= 0) v[p] = 1'b1;
        return v;
    endfunction

    function automatic void model_reset();
        m_pos  = -1;
        m_rem  = 0;
        m_busy = 1'b0;
        m_done = 1'b0;
    endfunction

    function automatic void model_clock();
        if (reset) begin
            model_reset();
        end else if (bus.nen1 || bus.nen2) begin
            model_reset();
        end else if (bus.load) begin
            m_pos  = int'(bus.sel);
            m_rem  = int'(bus.stepCount);
            m_busy = (m_rem != 0);
            m_done = 1'b0;
        end else if (m_busy) begin
            if (m_pos >= 0) m_pos = (m_pos + 1) % OUTS;
            m_rem  = m_rem - 1;
            m_busy = (m_rem != 0);
            m_done = (m_rem == 0);
        end else begin
            if (bus.step && m_pos >= 0) m_pos = (m_pos + 1) % OUTS;
            m_done = 1'b0;
        end
        exp_q.push_back(pos_to_q(m_pos));
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [OUTS-1:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s.queue: got empty want entry", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".q"},    32'(bus.q),     32'(e));
        check({tag, ".busy"}, 32'(bus.busy),  32'(m_busy));
        check({tag, ".done"}, 32'(bus.done),  32'(m_done));
        check({tag, ".dbg"},  32'(dbg_state), 32'(m_busy));
`ifdef DEC_SEQ_QN_EN
        check({tag, ".qn"},   32'(bus.qn),    32'(~e));
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit ld, input int s, input int cnt, input bit stp,
                         input bit n1, input bit n2);
        bus.load      = ld;
        bus.sel       = SELW'(s);
        bus.stepCount = CNTW'(cnt);
        bus.step      = stp;
        bus.nen1      = n1;
        bus.nen2      = n2;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_outputs(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back('0);
        check_outputs("reset");
`ifdef DEC_SEQ_QN_EN
        check("reset.qn_ff", 32'(bus.qn), 32'h0000_00FF);
`endif
        reset = 1'b0;

        // Load sel=5 with no burst.
        drive(1'b1, 5, 0, 1'b0, 1'b0, 1'b0);
        tick("load5");
        check("load5.const", 32'(bus.q), 32'h20);
        idle();
        tick("hold5");

        // Burst of 3 from sel=6: 0x40, 0x80, 0x01, 0x02 with done on 0x02.
        drive(1'b1, 6, 3, 1'b0, 1'b0, 1'b0);
        tick("b3_load");
        idle();
        tick("b3_r1");
        tick("b3_r2");
        tick("b3_r3");
        check("b3_done_q", 32'(bus.q), 32'h02);
        check("b3_done",   32'(bus.done), 32'h1);
        tick("b3_hold");

        // Single step wraps from bit 7 to bit 0.
        drive(1'b1, 7, 0, 1'b0, 1'b0, 1'b0);
        tick("wrap_load");
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        tick("wrap_step");
        check("wrap_const", 32'(bus.q), 32'h01);

        // Step on zero q stays zero.
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        tick("zero_clr");
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        tick("zero_step");

        // Step held during a burst adds no extra advance.
        drive(1'b1, 2, 2, 1'b0, 1'b0, 1'b0);
        tick("sb_load");
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        tick("sb_r1");
        tick("sb_r2");
        tick("sb_idle_step");
        idle();

        // Load preempts a burst on its second rotate.
        drive(1'b1, 0, 5, 1'b0, 1'b0, 1'b0);
        tick("pre_load");
        idle();
        tick("pre_r1");
        drive(1'b1, 3, 0, 1'b0, 1'b0, 1'b0);
        tick("pre_reload");
        check("pre_const", 32'(bus.q), 32'h08);
        idle();
        tick("pre_hold1");
        tick("pre_hold2");

        // Disable mid-burst aborts without done.
        drive(1'b1, 1, 4, 1'b0, 1'b0, 1'b0);
        tick("dis_load");
        idle();
        tick("dis_r1");
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        tick("dis_abort");
        idle();
        tick("dis_after1");
        tick("dis_after2");

        // Maximum burst length.
        drive(1'b1, 4, 15, 1'b0, 1'b0, 1'b0);
        tick("max_load");
        idle();
        for (int i = 0; i < 16; i++) tick("max_run");

        // Asynchronous reset mid-burst, observed before the next clock edge.
        drive(1'b1, 4, 6, 1'b0, 1'b0, 1'b0);
        tick("ar_load");
        idle();
        tick("ar_r1");
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        exp_q.push_back('0);
        check_outputs("async_rst");
`ifdef DEC_SEQ_QN_EN
        check("async_rst.qn_ff", 32'(bus.qn), 32'h0000_00FF);
`endif
        tick("ar_held");
        reset = 1'b0;
        tick("ar_after");

        // Randomized stimulus.
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, OUTS - 1)),
                  ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15)),
                  bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 31) == 0));
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
